// File: rtl/remap_accel_mul_pipe.sv
// -----------------------------------------------------------------------------
// remap_accel_mul_pipe
//   Pipelined multiplier for the remap coordinate/interpolation datapath.
//   Per-transaction operand signedness, runtime arithmetic right shift with
//   round-half-up, output saturation to P_W bits, and a tag sideband that
//   travels with each operation. A valid/ready handshake gives back-pressure.
//   The whole pipeline freezes while the output is stalled; bubbles are not
//   squeezed out.
//
//   Ranks: S1 operand register, then NUM_STAGE-1 product ranks (the first
//   forms the full product, the rest are pure delay), then the output register
//   where rounding, shift and saturation are applied. An op accepted on edge k
//   is visible on the outputs after edge k+NUM_STAGE. NUM_STAGE legal: 3..8.
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operands presented            in_ready  accepts this cycle
//   in_a/in_b  operands                      in_sign_a/in_sign_b  1: signed
//   in_shift   right shift of full product   in_tag    sideband
//   out_valid  result present                out_ready downstream accepts
//   out_p      rounded/shifted/saturated     out_sat   1: out_p clamped
//   out_tag    tag of this result
// -----------------------------------------------------------------------------
module remap_accel_mul_pipe #(
  parameter int A_W       = 11,
  parameter int B_W       = 11,
  parameter int P_W       = 22,
  parameter int SH_W      = 5,
  parameter int TAG_W     = 4,
  parameter int NUM_STAGE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_sign_a,
  input  logic             in_sign_b,
  input  logic [SH_W-1:0]  in_shift,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic             out_sat,
  output logic [TAG_W-1:0] out_tag
);

  localparam int FPW = A_W + B_W + 2;            // full signed product width
  localparam int EW  = FPW + 1;                  // rounding add cannot overflow here
  localparam int D   = NUM_STAGE - 1;            // product/delay ranks
  localparam int CW  = (EW > P_W + 1) ? EW : P_W + 1;

  localparam logic signed [CW-1:0] LIM_UMAX = {{(CW-P_W){1'b0}}, {P_W{1'b1}}};
  localparam logic signed [CW-1:0] LIM_SMAX = LIM_UMAX >> 1;
  localparam logic signed [CW-1:0] LIM_SMIN = ~LIM_SMAX;

  logic adv;

  assign in_ready = ~(out_valid & ~out_ready);
  assign adv      = in_ready;

  // S1: operand register
  logic             s1_v, s1_sa, s1_sb;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [SH_W-1:0]  s1_sh;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v   <= 1'b0;
      s1_sa  <= 1'b0;
      s1_sb  <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sh  <= '0;
      s1_tag <= '0;
    end else if (adv) begin
      s1_v   <= in_valid;
      s1_sa  <= in_sign_a;
      s1_sb  <= in_sign_b;
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_sh  <= in_shift;
      s1_tag <= in_tag;
    end
  end

  // One extra bit per operand lets a single signed multiply cover all four
  // signedness combinations.
  logic signed [A_W:0]     a_ext;
  logic signed [B_W:0]     b_ext;
  logic signed [FPW-1:0]   fp_new;

  assign a_ext  = {s1_sa & s1_a[A_W-1], s1_a};
  assign b_ext  = {s1_sb & s1_b[B_W-1], s1_b};
  assign fp_new = FPW'(a_ext) * FPW'(b_ext);

  // Product rank 0 holds the product, later ranks only delay it.
  logic                  pd_v   [D];
  logic signed [FPW-1:0] pd_fp  [D];
  logic                  pd_sgn [D];
  logic [SH_W-1:0]       pd_sh  [D];
  logic [TAG_W-1:0]      pd_tag [D];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) begin
        pd_v[i]   <= 1'b0;
        pd_fp[i]  <= '0;
        pd_sgn[i] <= 1'b0;
        pd_sh[i]  <= '0;
        pd_tag[i] <= '0;
      end
    end else if (adv) begin
      pd_v[0]   <= s1_v;
      pd_fp[0]  <= fp_new;
      pd_sgn[0] <= s1_sa | s1_sb;
      pd_sh[0]  <= s1_sh;
      pd_tag[0] <= s1_tag;
      for (int i = 1; i < D; i++) begin
        pd_v[i]   <= pd_v[i-1];
        pd_fp[i]  <= pd_fp[i-1];
        pd_sgn[i] <= pd_sgn[i-1];
        pd_sh[i]  <= pd_sh[i-1];
        pd_tag[i] <= pd_tag[i-1];
      end
    end
  end

  // Final stage: round-half-up, arithmetic shift, saturate.
  logic signed [EW-1:0] fp_x, rnd, sum, r;
  logic signed [CW-1:0] r_w, r_sat;
  logic                 sat_next;
  logic [SH_W-1:0]      sh_f;

  assign sh_f = pd_sh[D-1];

  always_comb begin
    fp_x     = EW'(pd_fp[D-1]);
    rnd      = EW'(1) << (sh_f - 1'b1);
    sum      = fp_x + rnd;
    r        = fp_x;
    sat_next = 1'b0;
    if (sh_f == '0) begin
      r = fp_x;
    end else if (int'(sh_f) >= FPW) begin
      // Everything shifted out: only the sign survives.
      r = fp_x[EW-1] ? '1 : '0;
    end else begin
      r = sum >>> sh_f;
    end
    r_w   = CW'(r);
    r_sat = r_w;
    if (pd_sgn[D-1]) begin
      if (r_w > LIM_SMAX) begin
        r_sat    = LIM_SMAX;
        sat_next = 1'b1;
      end else if (r_w < LIM_SMIN) begin
        r_sat    = LIM_SMIN;
        sat_next = 1'b1;
      end
    end else begin
      if (r_w > LIM_UMAX) begin
        r_sat    = LIM_UMAX;
        sat_next = 1'b1;
      end else if (r_w < 0) begin
        r_sat    = '0;
        sat_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_sat   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= pd_v[D-1];
      out_p     <= r_sat[P_W-1:0];
      out_sat   <= sat_next;
      out_tag   <= pd_tag[D-1];
    end
  end

endmodule

// File: tb/tb_remap_accel_mul_pipe.sv
module tb_remap_accel_mul_pipe;

  localparam int FPW = 24;

  logic        clk, reset_n, in_valid, in_sign_a, in_sign_b, out_ready;
  logic [10:0] in_a, in_b;
  logic [4:0]  in_shift;
  logic [3:0]  in_tag;

  logic        def_in_ready, def_out_valid, def_out_sat;
  logic [21:0] def_out_p;
  logic [3:0]  def_out_tag;
  logic        p8_in_ready, p8_out_valid, p8_out_sat;
  logic [7:0]  p8_out_p;
  logic [3:0]  p8_out_tag;
  logic        n3_in_ready, n3_out_valid, n3_out_sat;
  logic [21:0] n3_out_p;
  logic [3:0]  n3_out_tag;
  logic        n8_in_ready, n8_out_valid, n8_out_sat;
  logic [21:0] n8_out_p;
  logic [3:0]  n8_out_tag;

  int checks = 0;
  int failures = 0;

  remap_accel_mul_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(def_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .in_shift(in_shift), .in_tag(in_tag), .out_valid(def_out_valid),
    .out_ready(out_ready), .out_p(def_out_p), .out_sat(def_out_sat), .out_tag(def_out_tag));

  remap_accel_mul_pipe #(.P_W(8)) dut_p8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(p8_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .in_shift(in_shift), .in_tag(in_tag), .out_valid(p8_out_valid),
    .out_ready(out_ready), .out_p(p8_out_p), .out_sat(p8_out_sat), .out_tag(p8_out_tag));

  remap_accel_mul_pipe #(.NUM_STAGE(3)) dut_n3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(n3_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .in_shift(in_shift), .in_tag(in_tag), .out_valid(n3_out_valid),
    .out_ready(out_ready), .out_p(n3_out_p), .out_sat(n3_out_sat), .out_tag(n3_out_tag));

  remap_accel_mul_pipe #(.NUM_STAGE(8)) dut_n8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(n8_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
    .in_shift(in_shift), .in_tag(in_tag), .out_valid(n8_out_valid),
    .out_ready(out_ready), .out_p(n8_out_p), .out_sat(n8_out_sat), .out_tag(n8_out_tag));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Arithmetic reference: exact product, round-half-up shift, clamp.
  function automatic void ref_model(input logic [10:0] a, input logic [10:0] b,
                                    input bit sa, input bit sb, input int sh, input int pw,
                                    output longint p, output bit sat);
    longint av, bv, fp, r, lo, hi;
    av = (sa && a[10]) ? longint'(a) - 2048 : longint'(a);
    bv = (sb && b[10]) ? longint'(b) - 2048 : longint'(b);
    fp = av * bv;
    if (sh == 0)        r = fp;
    else if (sh >= FPW) r = (fp < 0) ? -1 : 0;
    else                r = (fp + (64'sd1 << (sh - 1))) >>> sh;
    if (sa || sb) begin
      lo = -(64'sd1 << (pw - 1));
      hi = (64'sd1 << (pw - 1)) - 1;
    end else begin
      lo = 0;
      hi = (64'sd1 << pw) - 1;
    end
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    p = r & ((64'sd1 << pw) - 1);
  endfunction

  task automatic drive(input logic [10:0] a, input logic [10:0] b, input bit sa, input bit sb,
                       input int sh, input int tag);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_sign_a = sa;
    in_sign_b = sb;
    in_shift  = 5'(sh);
    in_tag    = 4'(tag);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Presents one op on an idle pipeline, returns the number of edges after
  // the accepting edge until out_valid is seen (bounded). Ends at a negedge.
  task automatic do_single(input logic [10:0] a, input logic [10:0] b, input bit sa,
                           input bit sb, input int sh, input int tag, output int lat);
    @(posedge clk);
    #1 drive(a, b, sa, sb, sh, tag);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!def_out_valid && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    reset_n   = 1'b0;
    drive(11'd100, 11'd200, 1'b0, 1'b0, 0, 5);
    repeat (3) @(negedge clk);
    checks++; if (def_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", def_out_valid); end
    checks++; if (def_out_p !== 22'd0) begin failures++; $display("FAIL reset_out_p got=%0d want=0", def_out_p); end
    checks++; if (def_out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b want=0", def_out_sat); end
    checks++; if (def_out_tag !== 4'd0) begin failures++; $display("FAIL reset_out_tag got=%0d want=0", def_out_tag); end
    @(posedge clk);
    #1 reset_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (def_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", def_in_ready); end
    checks++; if (def_out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_valid got=%b want=0", def_out_valid); end
  endtask

  task automatic test_unsigned_max();
    int lat;
    do_single(11'd2047, 11'd2047, 1'b0, 1'b0, 0, 10, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL umax_latency got=%0d want=4", lat); end
    checks++; if (def_out_p !== 22'd4190209) begin failures++; $display("FAIL umax_p got=%0d want=4190209", def_out_p); end
    checks++; if (def_out_sat !== 1'b0) begin failures++; $display("FAIL umax_sat got=%b want=0", def_out_sat); end
    checks++; if (def_out_tag !== 4'd10) begin failures++; $display("FAIL umax_tag got=%0d want=10", def_out_tag); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (def_out_valid !== 1'b0) begin failures++; $display("FAIL umax_single_result got=%b want=0", def_out_valid); end
  endtask

  task automatic test_signed_sat();
    int lat;
    do_single(11'h7FD, 11'd5, 1'b1, 1'b0, 0, 3, lat);
    checks++; if (p8_out_valid !== 1'b1) begin failures++; $display("FAIL s_neg15_valid got=%b want=1", p8_out_valid); end
    checks++; if (p8_out_p !== 8'hF1) begin failures++; $display("FAIL s_neg15_p8 got=%h want=f1", p8_out_p); end
    checks++; if (p8_out_sat !== 1'b0) begin failures++; $display("FAIL s_neg15_sat8 got=%b want=0", p8_out_sat); end
    checks++; if (def_out_p !== 22'h3FFFF1) begin failures++; $display("FAIL s_neg15_p22 got=%h want=3ffff1", def_out_p); end
    do_single(11'h400, 11'd1023, 1'b1, 1'b0, 0, 4, lat);
    checks++; if (p8_out_p !== 8'h80) begin failures++; $display("FAIL s_min_p8 got=%h want=80", p8_out_p); end
    checks++; if (p8_out_sat !== 1'b1) begin failures++; $display("FAIL s_min_sat8 got=%b want=1", p8_out_sat); end
    checks++; if (def_out_p !== 22'h300400) begin failures++; $display("FAIL s_min_p22 got=%h want=300400", def_out_p); end
    checks++; if (def_out_sat !== 1'b0) begin failures++; $display("FAIL s_min_sat22 got=%b want=0", def_out_sat); end
    do_single(11'd100, 11'd100, 1'b1, 1'b1, 0, 5, lat);
    checks++; if (p8_out_p !== 8'h7F || p8_out_sat !== 1'b1) begin failures++; $display("FAIL s_max_p8 got=%h sat=%b want=7f sat=1", p8_out_p, p8_out_sat); end
    do_single(11'd2047, 11'd2047, 1'b0, 1'b0, 0, 6, lat);
    checks++; if (p8_out_p !== 8'hFF || p8_out_sat !== 1'b1) begin failures++; $display("FAIL u_max_p8 got=%h sat=%b want=ff sat=1", p8_out_p, p8_out_sat); end
  endtask

  task automatic test_rounding();
    int lat;
    do_single(11'd7, 11'd3, 1'b0, 1'b0, 1, 1, lat);
    checks++; if (def_out_p !== 22'd11 || def_out_sat !== 1'b0) begin failures++; $display("FAIL rnd_sh1 got=%0d sat=%b want=11 sat=0", def_out_p, def_out_sat); end
    do_single(11'd7, 11'd3, 1'b0, 1'b0, 2, 2, lat);
    checks++; if (def_out_p !== 22'd5) begin failures++; $display("FAIL rnd_sh2 got=%0d want=5", def_out_p); end
    do_single(11'h7F9, 11'd3, 1'b1, 1'b0, 1, 3, lat);
    checks++; if (def_out_p !== 22'h3FFFF6) begin failures++; $display("FAIL rnd_neg_sh1 got=%h want=3ffff6", def_out_p); end
    do_single(11'h7F9, 11'd3, 1'b1, 1'b0, 24, 4, lat);
    checks++; if (def_out_p !== 22'h3FFFFF) begin failures++; $display("FAIL rnd_neg_sh24 got=%h want=3fffff", def_out_p); end
    do_single(11'h7F9, 11'd3, 1'b1, 1'b0, 31, 5, lat);
    checks++; if (def_out_p !== 22'h3FFFFF) begin failures++; $display("FAIL rnd_neg_sh31 got=%h want=3fffff", def_out_p); end
    do_single(11'd7, 11'd3, 1'b0, 1'b0, 31, 6, lat);
    checks++; if (def_out_p !== 22'd0 || def_out_sat !== 1'b0) begin failures++; $display("FAIL rnd_pos_sh31 got=%0d sat=%b want=0 sat=0", def_out_p, def_out_sat); end
    do_single(11'd2047, 11'd2047, 1'b0, 1'b0, 23, 7, lat);
    checks++; if (def_out_p !== 22'd0) begin failures++; $display("FAIL rnd_sh23 got=%0d want=0", def_out_p); end
  endtask

  task automatic test_back_to_back();
    longint exp_p[$];
    bit     exp_sat[$];
    int     exp_tag[$];
    longint ep;
    bit     es, prev_stall, in_acc, out_acc;
    logic [21:0] held_p;
    logic [3:0]  held_tag;
    int     i, got, cyc, nstall;
    pulse_reset();
    i = 0; got = 0; cyc = 0; nstall = 0; prev_stall = 1'b0;
    held_p = '0; held_tag = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 drive(11'(5), 11'(2047), 1'b0, 1'b0, 0, 0);
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      in_acc  = in_valid && def_in_ready;
      out_acc = def_out_valid && out_ready;
      checks++; if (def_in_ready !== !(def_out_valid && !out_ready)) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b", cyc, def_in_ready); end
      if (prev_stall) begin
        nstall++;
        checks++;
        if (def_out_valid !== 1'b1 || def_out_p !== held_p || def_out_tag !== held_tag) begin
          failures++; $display("FAIL bp_hold cyc=%0d got v=%b p=%h t=%0d want v=1 p=%h t=%0d", cyc, def_out_valid, def_out_p, def_out_tag, held_p, held_tag);
        end
      end
      prev_stall = def_out_valid && !out_ready;
      held_p = def_out_p; held_tag = def_out_tag;
      if (out_acc) begin
        checks++;
        if (exp_p.size() == 0) begin
          failures++; $display("FAIL bp_extra_result tag=%0d want=none", def_out_tag);
        end else begin
          ep = exp_p.pop_front(); es = exp_sat.pop_front();
          if (longint'(def_out_p) !== ep || def_out_sat !== es || int'(def_out_tag) !== exp_tag[0]) begin
            failures++; $display("FAIL bp_result got p=%0d sat=%b tag=%0d want p=%0d sat=%b tag=%0d", def_out_p, def_out_sat, def_out_tag, ep, es, exp_tag[0]);
          end
          void'(exp_tag.pop_front());
        end
        got++;
      end
      if (in_acc) begin
        ref_model(in_a, in_b, in_sign_a, in_sign_b, int'(in_shift), 22, ep, es);
        exp_p.push_back(ep); exp_sat.push_back(es); exp_tag.push_back(int'(in_tag));
        i++;
      end
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 1));
      if (i < 10) drive(11'(i * 113 + 5), 11'(2047 - i * 37), 1'(i % 2), 1'b0, i % 4, i);
      else in_valid = 1'b0;
      cyc++;
    end
    checks++; if (got !== 10) begin failures++; $display("FAIL bp_count got=%0d want=10", got); end
    checks++; if (nstall == 0) begin failures++; $display("FAIL bp_no_stall_seen got=0 want>0"); end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_midflight();
    int lat, stale;
    out_ready = 1'b1;
    @(posedge clk);
    #1 drive(11'd5, 11'd6, 1'b0, 1'b0, 0, 1);
    @(posedge clk);
    #1 drive(11'd7, 11'd8, 1'b0, 1'b0, 0, 2);
    @(posedge clk);
    #1 drive(11'd9, 11'd10, 1'b0, 1'b0, 0, 3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (def_out_valid !== 1'b1 || def_out_p !== 22'd30) begin failures++; $display("FAIL mid_first_out got v=%b p=%0d want v=1 p=30", def_out_valid, def_out_p); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (def_out_valid !== 1'b0 || def_out_p !== 22'd0 || def_out_sat !== 1'b0 || def_out_tag !== 4'd0) begin
      failures++; $display("FAIL mid_async_clear got v=%b p=%0d s=%b t=%0d want all 0", def_out_valid, def_out_p, def_out_sat, def_out_tag);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (def_in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b want=1", def_in_ready); end
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (def_out_valid) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale got=%0d want=0", stale); end
    do_single(11'd9, 11'd9, 1'b0, 1'b0, 0, 7, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL mid_latency got=%0d want=4", lat); end
    checks++; if (def_out_p !== 22'd81 || def_out_tag !== 4'd7) begin failures++; $display("FAIL mid_next_op got p=%0d t=%0d want p=81 t=7", def_out_p, def_out_tag); end
  endtask

  task automatic test_sweep();
    logic [10:0] op_a[20], op_b[20];
    bit          op_sa[20], op_sb[20];
    int          op_sh[20];
    longint      ep;
    bit          es;
    int          j;
    for (int k = 0; k < 20; k++) begin
      op_a[k]  = 11'($urandom);
      op_b[k]  = 11'($urandom);
      op_sa[k] = 1'($urandom);
      op_sb[k] = 1'($urandom);
      op_sh[k] = int'($urandom_range(0, 27));
    end
    pulse_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1 drive(op_a[0], op_b[0], op_sa[0], op_sb[0], op_sh[0], 0);
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc + 1 < 20) drive(op_a[cyc+1], op_b[cyc+1], op_sa[cyc+1], op_sb[cyc+1], op_sh[cyc+1], cyc + 1);
      else in_valid = 1'b0;
      @(negedge clk);
      j = cyc - 3;
      checks++; if (n3_out_valid !== (j >= 0 && j < 20)) begin failures++; $display("FAIL n3_valid cyc=%0d got=%b", cyc, n3_out_valid); end
      if (j >= 0 && j < 20) begin
        ref_model(op_a[j], op_b[j], op_sa[j], op_sb[j], op_sh[j], 22, ep, es);
        checks++;
        if (longint'(n3_out_p) !== ep || n3_out_sat !== es || int'(n3_out_tag) !== (j % 16)) begin
          failures++; $display("FAIL n3_result op=%0d got p=%h s=%b t=%0d want p=%h s=%b t=%0d", j, n3_out_p, n3_out_sat, n3_out_tag, ep, es, j % 16);
        end
      end
      j = cyc - 8;
      checks++; if (n8_out_valid !== (j >= 0 && j < 20)) begin failures++; $display("FAIL n8_valid cyc=%0d got=%b", cyc, n8_out_valid); end
      if (j >= 0 && j < 20) begin
        ref_model(op_a[j], op_b[j], op_sa[j], op_sb[j], op_sh[j], 22, ep, es);
        checks++;
        if (longint'(n8_out_p) !== ep || n8_out_sat !== es || int'(n8_out_tag) !== (j % 16)) begin
          failures++; $display("FAIL n8_result op=%0d got p=%h s=%b t=%0d want p=%h s=%b t=%0d", j, n8_out_p, n8_out_sat, n8_out_tag, ep, es, j % 16);
        end
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sign_a = 1'b0; in_sign_b = 1'b0;
    in_shift = '0; in_tag = '0; out_ready = 1'b1; reset_n = 1'b0;
    test_reset();
    test_unsigned_max();
    test_signed_sat();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
